// File: rtl/bc_seq_gen.sv
// bc_seq_gen: generates an a/b/c strobe sequence on request.
// a frames the whole sequence, b runs for B_LEN cycles, c closes it for one
// cycle, and a may linger for A_TAIL extra cycles. Every output is a flop
// loaded from the next-state logic, so no input reaches an output
// combinationally.
module bc_seq_gen #(
  parameter int B_LEN  = 3,
  parameter int A_TAIL = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             start_ack,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] seq_cnt
);

  typedef enum logic [1:0] {IDLE, BPH, CPH, TAIL} state_t;

  // Down-counter reload values; a phase ends when the counter reads zero.
  localparam logic [3:0] B_LOAD = 4'(B_LEN - 1);
  localparam logic [3:0] T_LOAD = (A_TAIL > 0) ? 4'(A_TAIL - 1) : 4'd0;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             a_nxt, b_nxt, c_nxt, busy_nxt;
  logic             start_ack_nxt, done_nxt, aborted_nxt;
  logic [CNT_W-1:0] seq_cnt_nxt;

  // Next state, next counter and the output values that follow from them.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    a_nxt         = 1'b0;
    b_nxt         = 1'b0;
    c_nxt         = 1'b0;
    start_ack_nxt = 1'b0;
    done_nxt      = 1'b0;
    aborted_nxt   = 1'b0;
    seq_cnt_nxt   = seq_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = BPH;
          cnt_nxt       = B_LOAD;
          a_nxt         = 1'b1;
          b_nxt         = 1'b1;
          start_ack_nxt = 1'b1;
        end
      end
      BPH: begin
        if (abort) begin
          state_nxt   = IDLE;
          cnt_nxt     = 4'd0;
          aborted_nxt = 1'b1;
        end else if (cnt == 4'd0) begin
          state_nxt   = CPH;
          a_nxt       = 1'b1;
          c_nxt       = 1'b1;
          done_nxt    = 1'b1;
          seq_cnt_nxt = seq_cnt + CNT_W'(1);
        end else begin
          cnt_nxt = cnt - 4'd1;
          a_nxt   = 1'b1;
          b_nxt   = 1'b1;
        end
      end
      CPH: begin
        if (abort) begin
          state_nxt   = IDLE;
          cnt_nxt     = 4'd0;
          aborted_nxt = 1'b1;
        end else if (A_TAIL == 0) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          state_nxt = TAIL;
          cnt_nxt   = T_LOAD;
          a_nxt     = 1'b1;
        end
      end
      TAIL: begin
        if (abort) begin
          state_nxt   = IDLE;
          cnt_nxt     = 4'd0;
          aborted_nxt = 1'b1;
        end else if (cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
          a_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      busy      <= 1'b0;
      start_ack <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      seq_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      c         <= c_nxt;
      busy      <= busy_nxt;
      start_ack <= start_ack_nxt;
      done      <= done_nxt;
      aborted   <= aborted_nxt;
      seq_cnt   <= seq_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_bc_seq_gen.sv
// Scoreboard bench for bc_seq_gen: four instances cover the default
// parameters, a two-cycle a tail, a 2-bit sequence counter and B_LEN=1.
// Flag vectors are {a, b, c, busy, start_ack, done, aborted}.
module tb_bc_seq_gen;

  typedef struct packed {
    logic [6:0] flags;
    logic [7:0] cnt;
  } exp_t;

  localparam logic [6:0] IDL = 7'b0000000;
  localparam logic [6:0] ACK = 7'b1101100;
  localparam logic [6:0] BPH = 7'b1101000;
  localparam logic [6:0] CPH = 7'b1011010;
  localparam logic [6:0] TLL = 7'b1001000;
  localparam logic [6:0] ABT = 7'b0000001;

  logic clk;
  logic rst_v   [4];
  logic start_v [4];
  logic abort_v [4];

  logic [6:0] obs_flags [4];
  logic [7:0] obs_cnt   [4];

  logic       a0, b0, c0, y0, k0, d0, x0;
  logic       a1, b1, c1, y1, k1, d1, x1;
  logic       a2, b2, c2, y2, k2, d2, x2;
  logic       a3, b3, c3, y3, k3, d3, x3;
  logic [7:0] n0, n1, n3;
  logic [1:0] n2;

  exp_t sbq [4][$];
  exp_t e;
  int   errors;
  int   checks;
  logic prop_en;

  bc_seq_gen dut0 (.clk(clk), .rst_n(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]),
    .a(a0), .b(b0), .c(c0), .busy(y0), .start_ack(k0), .done(d0), .aborted(x0), .seq_cnt(n0));

  bc_seq_gen #(.A_TAIL(2)) dut1 (.clk(clk), .rst_n(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]),
    .a(a1), .b(b1), .c(c1), .busy(y1), .start_ack(k1), .done(d1), .aborted(x1), .seq_cnt(n1));

  bc_seq_gen #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_v[2]), .start(start_v[2]), .abort(abort_v[2]),
    .a(a2), .b(b2), .c(c2), .busy(y2), .start_ack(k2), .done(d2), .aborted(x2), .seq_cnt(n2));

  bc_seq_gen #(.B_LEN(1)) dut3 (.clk(clk), .rst_n(rst_v[3]), .start(start_v[3]), .abort(abort_v[3]),
    .a(a3), .b(b3), .c(c3), .busy(y3), .start_ack(k3), .done(d3), .aborted(x3), .seq_cnt(n3));

  always_comb begin
    obs_flags[0] = {a0, b0, c0, y0, k0, d0, x0};
    obs_flags[1] = {a1, b1, c1, y1, k1, d1, x1};
    obs_flags[2] = {a2, b2, c2, y2, k2, d2, x2};
    obs_flags[3] = {a3, b3, c3, y3, k3, d3, x3};
    obs_cnt[0]   = n0;
    obs_cnt[1]   = n1;
    obs_cnt[2]   = {6'd0, n2};
    obs_cnt[3]   = n3;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A full default-length sequence keeps a high from the first b to the c.
  property p_window;
    @(posedge clk) disable iff (!prop_en)
      $rose(b0) |-> a0 throughout (b0[*3] ##1 c0);
  endproperty
  a_window: assert property (p_window)
    else begin
      errors++;
      $display("[TB] FAIL window property: a/b/c shape broken at time %0t", $time);
    end

  // Drive one edge worth of inputs and queue the expected post-edge outputs.
  task automatic applyStimulus(input int i, input logic r, input logic s, input logic ab,
                               input logic [6:0] ef, input logic [7:0] ec);
    @(negedge clk);
    rst_v[i]   = r;
    start_v[i] = s;
    abort_v[i] = ab;
    @(posedge clk);
    sbq[i].push_back('{flags: ef, cnt: ec});
  endtask

  // Compare one queued expectation against the presented outputs.
  task automatic checkOutput(input int i);
    e = sbq[i].pop_front();
    checks++;
    if (obs_flags[i] !== e.flags || obs_cnt[i] !== e.cnt) begin
      errors++;
      $display("[TB] FAIL dut%0d outputs: got flags=%b cnt=%0d, expected flags=%b cnt=%0d",
               i, obs_flags[i], obs_cnt[i], e.flags, e.cnt);
    end
  endtask

  // Monitor: shortly after each edge, check every instance with a pending expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (sbq[i].size() > 0) checkOutput(i);
    end
  end

  initial begin
    logic [7:0] cnt_before [4];
    logic [7:0] cnt_after  [4];
    errors  = 0;
    checks  = 0;
    prop_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rst_v[i]   = 1'b0;
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end
    cnt_before = '{8'd0, 8'd1, 8'd2, 8'd3};
    cnt_after  = '{8'd1, 8'd2, 8'd3, 8'd0};

    // Defaults: reset, a basic sequence, ignored starts, aborts, reset in CPH.
    prop_en = 1'b1;
    applyStimulus(0, 0, 0, 0, IDL, 0);
    applyStimulus(0, 0, 1, 1, IDL, 0);
    applyStimulus(0, 1, 1, 0, ACK, 0);
    applyStimulus(0, 1, 1, 0, BPH, 0);
    applyStimulus(0, 1, 0, 0, BPH, 0);
    applyStimulus(0, 1, 0, 0, CPH, 1);
    applyStimulus(0, 1, 1, 0, IDL, 1);
    prop_en = 1'b0;
    applyStimulus(0, 1, 1, 1, ACK, 1);
    applyStimulus(0, 1, 0, 0, BPH, 1);
    applyStimulus(0, 1, 0, 1, ABT, 1);
    applyStimulus(0, 1, 0, 0, IDL, 1);
    applyStimulus(0, 1, 0, 1, IDL, 1);
    applyStimulus(0, 1, 1, 0, ACK, 1);
    applyStimulus(0, 1, 0, 0, BPH, 1);
    applyStimulus(0, 1, 0, 0, BPH, 1);
    applyStimulus(0, 1, 0, 0, CPH, 2);
    applyStimulus(0, 1, 0, 1, ABT, 2);
    applyStimulus(0, 1, 0, 0, IDL, 2);
    applyStimulus(0, 1, 1, 0, ACK, 2);
    applyStimulus(0, 1, 0, 0, BPH, 2);
    applyStimulus(0, 1, 0, 0, BPH, 2);
    applyStimulus(0, 1, 0, 0, CPH, 3);
    applyStimulus(0, 0, 1, 1, IDL, 0);
    applyStimulus(0, 1, 0, 0, IDL, 0);

    // A_TAIL=2 with start held: 6 busy cycles, one idle cycle, repeat; abort in tail.
    applyStimulus(1, 0, 0, 0, IDL, 0);
    applyStimulus(1, 1, 1, 0, ACK, 0);
    applyStimulus(1, 1, 1, 0, BPH, 0);
    applyStimulus(1, 1, 1, 0, BPH, 0);
    applyStimulus(1, 1, 1, 0, CPH, 1);
    applyStimulus(1, 1, 1, 0, TLL, 1);
    applyStimulus(1, 1, 1, 0, TLL, 1);
    applyStimulus(1, 1, 1, 0, IDL, 1);
    applyStimulus(1, 1, 1, 0, ACK, 1);
    applyStimulus(1, 1, 1, 0, BPH, 1);
    applyStimulus(1, 1, 1, 0, BPH, 1);
    applyStimulus(1, 1, 1, 0, CPH, 2);
    applyStimulus(1, 1, 1, 0, TLL, 2);
    applyStimulus(1, 1, 1, 0, TLL, 2);
    applyStimulus(1, 1, 1, 0, IDL, 2);
    applyStimulus(1, 1, 1, 0, ACK, 2);
    applyStimulus(1, 1, 0, 0, BPH, 2);
    applyStimulus(1, 1, 0, 0, BPH, 2);
    applyStimulus(1, 1, 0, 0, CPH, 3);
    applyStimulus(1, 1, 0, 0, TLL, 3);
    applyStimulus(1, 1, 0, 1, ABT, 3);
    applyStimulus(1, 1, 0, 0, IDL, 3);

    // CNT_W=2: four completed sequences take the count 1, 2, 3, 0.
    applyStimulus(2, 0, 0, 0, IDL, 0);
    for (int s = 0; s < 4; s++) begin
      applyStimulus(2, 1, 1, 0, ACK, cnt_before[s]);
      applyStimulus(2, 1, 0, 0, BPH, cnt_before[s]);
      applyStimulus(2, 1, 0, 0, BPH, cnt_before[s]);
      applyStimulus(2, 1, 0, 0, CPH, cnt_after[s]);
      applyStimulus(2, 1, 0, 0, IDL, cnt_after[s]);
    end

    // B_LEN=1: one b cycle then c; a held start still leaves one idle cycle.
    applyStimulus(3, 0, 0, 0, IDL, 0);
    applyStimulus(3, 1, 1, 0, ACK, 0);
    applyStimulus(3, 1, 0, 0, CPH, 1);
    applyStimulus(3, 1, 0, 0, IDL, 1);
    applyStimulus(3, 1, 1, 0, ACK, 1);
    applyStimulus(3, 1, 1, 0, CPH, 2);
    applyStimulus(3, 1, 1, 0, IDL, 2);
    applyStimulus(3, 1, 1, 0, ACK, 2);
    applyStimulus(3, 1, 0, 0, CPH, 3);
    applyStimulus(3, 1, 0, 0, IDL, 3);

    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin
        errors++;
        $display("[TB] FAIL drain dut%0d: %0d expectations left, expected 0", i, sbq[i].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bc_seq_gen.md
BC_SEQ_GEN -- requirements
Module: bc_seq_gen

Interface
REQ-001 SHALL provide parameter B_LEN, default 3, number of consecutive b cycles per sequence (legal 1..15).
REQ-002 SHALL provide parameter A_TAIL, default 0, extra cycles a stays high after the c cycle (legal 0..7).
REQ-003 SHALL provide parameter CNT_W, default 8, width of the completed-sequence counter.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request to launch one sequence; sampled only in IDLE.
REQ-007 abort  input  1  terminate an in-progress sequence.
REQ-008 a  output  1  window qualifier; high for the entire b..c sequence (plus tail).
REQ-009 b  output  1  data phase strobe; high for exactly B_LEN consecutive cycles.
REQ-010 c  output  1  terminator strobe; high for exactly one cycle after the last b cycle.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 start_ack  output  1  one-cycle pulse when start is accepted.
REQ-013 done  output  1  one-cycle pulse coincident with the c cycle.
REQ-014 aborted  output  1  one-cycle pulse the cycle after abort is taken.
REQ-015 seq_cnt  output  CNT_W  count of completed sequences (c issued), wraps at 2^CNT_W.

Function
REQ-016 All outputs SHALL be registered; no combinational path from input to output.
REQ-017 FSM states SHALL be IDLE, BPH, CPH, TAIL.
REQ-018 IDLE: start=1 at edge k SHALL move to BPH; from edge k, a=1, b=1, start_ack=1 for one cycle.
REQ-019 BPH SHALL hold a=1, b=1, c=0 for B_LEN cycles total (edges k..k+B_LEN-1), using a 4-bit down-counter.
REQ-020 After the last BPH cycle, CPH SHALL last one cycle with a=1, b=0, c=1, done=1; seq_cnt increments at that edge.
REQ-021 After CPH: if A_TAIL=0, go to IDLE with a=0; else go to TAIL with a=1, b=0, c=0 for A_TAIL cycles, then IDLE.
REQ-022 b and c SHALL never be high in the same cycle; a SHALL be high in every cycle b or c is high.
REQ-023 start while busy=1 SHALL be ignored (no ack, no queuing); start on the edge leaving the last state SHALL also be ignored, guaranteeing at least one idle cycle (b low) between sequences.
REQ-024 abort=1 at any edge in BPH, CPH or TAIL SHALL force a=b=c=0, go to IDLE, and pulse aborted; seq_cnt unchanged unless the abort edge is the one ending CPH (c already issued, count already taken).
REQ-025 abort and start asserted together in IDLE: start SHALL win; abort in IDLE has no effect.
REQ-026 seq_cnt SHALL wrap from 2^CNT_W-1 to 0 without any flag.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force state IDLE, a=b=c=0, busy=start_ack=done=aborted=0, seq_cnt=0, counters cleared.
REQ-028 Reset mid-sequence SHALL override abort and start; outputs low from the reset edge, no done or aborted pulse.
REQ-029 After rst_n returns high, start SHALL be accepted at the first subsequent edge.

Verification
REQ-030 Defaults, start pulse at edge 3 -> a=1 edges 3..6, b=1 edges 3..5, c=1 edge 6, done edge 6, seq_cnt=1; concurrent assertion $rose(b) |-> a throughout (b[*3] ##1 c) passes.
REQ-031 A_TAIL=2, start held high continuously -> sequences of 6 busy cycles separated by exactly one idle cycle; start_ack once per sequence.
REQ-032 abort at second b cycle -> a=b=0 next cycle, no c, aborted=1 one cycle, seq_cnt unchanged.
REQ-033 rst_n=0 during CPH -> c=0 from reset edge, seq_cnt=0, no done pulse.
REQ-034 CNT_W=2, four completed sequences -> seq_cnt goes 1,2,3,0.
REQ-035 B_LEN=1 -> b one cycle, c the next, a two cycles; b and c never overlap.
